spi_byte_sequencer: RTL

Multi-byte transaction sequencer that sits directly upstream of the byte-level SPI driver. It buffers outgoing bytes in a TX FIFO and runs one chip-select-framed transaction of N bytes. For each byte it hands the driver one byte and a one-cycle start pulse, waits for the driver's enable to drop, and returns the received byte on a streaming output. Software/host logic sees a simple push-bytes, then `go`, then `done` interface instead of per-byte handshaking.

---
 rtl/spi_pkg.sv | 10 +
 rtl/spi_sync_fifo.sv | 51 +++++
 rtl/spi_byte_sequencer.sv | 110 +++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and defaults for the SPI byte sequencer slice.
//   spi_byte_t  - one SPI data byte
//   seq_state_e - sequencer FSM states
//   SEQ_DEPTH / SEQ_LEN_W - default TX FIFO depth and go_len width
package spi_pkg;
    typedef logic [7:0] spi_byte_t;
    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, FINISH} seq_state_e;
    localparam int SEQ_DEPTH = 8;
    localparam int SEQ_LEN_W = 4;
endpackage

// File: rtl/spi_sync_fifo.sv
// spi_sync_fifo: DEPTH x 8 synchronous FIFO with registered full/empty flags.
//   clk, rst        - clock, asynchronous active-high reset
//   i_wr, i_wdata   - push request and data (ignored while full)
//   i_rd            - pop request (ignored while empty)
//   o_rdata         - head of queue (show-ahead)
//   o_full, o_empty - registered status flags
module spi_sync_fifo
    import spi_pkg::*;
#(
    parameter int DEPTH = SEQ_DEPTH
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_wr,
    input  spi_byte_t i_wdata,
    input  logic      i_rd,
    output spi_byte_t o_rdata,
    output logic      o_full,
    output logic      o_empty
);
    localparam int AW = $clog2(DEPTH);
    spi_byte_t   r_mem [DEPTH];
    logic [AW:0] r_wptr, r_rptr;
    logic        r_full, r_empty;
    logic        w_push, w_pop;
    logic [AW:0] w_wptr_n, w_rptr_n;
    assign w_push   = i_wr && !r_full;
    assign w_pop    = i_rd && !r_empty;
    assign w_wptr_n = r_wptr + (AW+1)'(w_push);
    assign w_rptr_n = r_rptr + (AW+1)'(w_pop);
    assign o_rdata  = r_mem[r_rptr[AW-1:0]];
    assign o_full   = r_full;
    assign o_empty  = r_empty;
    // Flags are computed from the next pointers so they are valid the cycle after the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_wptr  <= w_wptr_n;
            r_rptr  <= w_rptr_n;
            r_full  <= (w_wptr_n[AW] != w_rptr_n[AW]) && (w_wptr_n[AW-1:0] == w_rptr_n[AW-1:0]);
            r_empty <= w_wptr_n == w_rptr_n;
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end
endmodule

// File: rtl/spi_byte_sequencer.sv
// spi_byte_sequencer: runs one cs_n-framed multi-byte transaction over a byte-level SPI driver.
//   clk, rst                     - clock, asynchronous active-high reset
//   i_tx_data/i_tx_valid/o_tx_ready - TX byte enqueue into the internal FIFO
//   i_go, i_go_len               - start a transaction of i_go_len+1 bytes (IDLE only)
//   o_busy, o_done               - transaction in progress / one-cycle completion pulse
//   o_cs_n                       - active-low chip select framing the transaction
//   o_rx_data, o_rx_valid        - received byte stream, one pulse per byte
//   o_drv_data, o_drv_start      - byte and start pulse to the driver
//   i_drv_busy, i_drv_rx         - driver busy and received byte
module spi_byte_sequencer
    import spi_pkg::*;
#(
    parameter int DEPTH = SEQ_DEPTH,
    parameter int LEN_W = SEQ_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  spi_byte_t        i_tx_data,
    input  logic             i_tx_valid,
    output logic             o_tx_ready,
    input  logic             i_go,
    input  logic [LEN_W-1:0] i_go_len,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_cs_n,
    output spi_byte_t        o_rx_data,
    output logic             o_rx_valid,
    output spi_byte_t        o_drv_data,
    output logic             o_drv_start,
    input  logic             i_drv_busy,
    input  spi_byte_t        i_drv_rx
);
    seq_state_e       r_state;
    logic [LEN_W-1:0] r_rem;
    logic             r_busy, r_done, r_cs_n, r_rx_valid, r_start;
    spi_byte_t        r_rx_data, r_drv_data;
    spi_byte_t        w_head;
    logic             w_full, w_empty;
    spi_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (i_tx_valid),
        .i_wdata (i_tx_data),
        .i_rd    (r_state == LOAD),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
    assign o_tx_ready  = !w_full;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_cs_n      = r_cs_n;
    assign o_rx_data   = r_rx_data;
    assign o_rx_valid  = r_rx_valid;
    assign o_drv_data  = r_drv_data;
    assign o_drv_start = r_start;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rem      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_drv_data <= '0;
            r_start    <= 1'b0;
        end else begin
            r_start    <= 1'b0;
            r_rx_valid <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                IDLE: begin
                    // busy stays high through the done cycle, then follows go
                    r_busy <= i_go;
                    if (i_go) begin
                        r_rem   <= i_go_len;
                        r_cs_n  <= 1'b0;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    if (!w_empty) begin
                        r_drv_data <= w_head;
                        r_start    <= 1'b1;
                        r_state    <= START;
                    end
                end
                START: r_state <= WAIT_BUSY;
                WAIT_BUSY: begin
                    if (i_drv_busy) r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!i_drv_busy) begin
                        r_rx_data  <= i_drv_rx;
                        r_rx_valid <= 1'b1;
                        r_rem      <= r_rem - 1'b1;
                        r_state    <= (r_rem == '0) ? FINISH : LOAD;
                    end
                end
                FINISH: begin
                    r_cs_n  <= 1'b1;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
